dlx_fwd_scoreboard: RTL and testbench



---
 rtl/dlx_pipe_pkg.sv | 15 +
 rtl/dlx_fwd_match.sv | 40 ++++
 rtl/dlx_fwd_scoreboard.sv | 77 +++++++
 tb/tb_dlx_fwd_scoreboard.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dlx_pipe_pkg.sv
// Shared DLX pipeline types: per-stage scoreboard slot and register-file constants.
package dlx_pipe_pkg;

  localparam int unsigned DEF_REG_W = 5;

  localparam logic [DEF_REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic [DEF_REG_W-1:0] rd;
    logic                 is_load;
  } slot_t;

endpackage

// File: rtl/dlx_fwd_match.sv
// Priority match of one ID source operand against all tracked post-ID slots.
module dlx_fwd_match
  import dlx_pipe_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_W      = DEF_REG_W,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 1
) (
  input  slot_t [DEPTH-1:0]      slots,
  input  logic  [REG_W-1:0]      src,
  input  logic  [DEPTH*XLEN-1:0] stage_data,
  output logic                   hit_c,
  output logic                   stall_c,
  output logic  [XLEN-1:0]       data_c
);

  logic found;

  // Lowest slot index is the youngest producer; first match wins.
  always_comb begin
    hit_c   = 1'b0;
    stall_c = 1'b0;
    data_c  = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!found && slots[k].valid && slots[k].we &&
          (REG_W'(slots[k].rd) == src) && (src != REG_W'(REG_ZERO))) begin
        found = 1'b1;
        if (!slots[k].is_load || (k >= LOAD_STAGE)) begin
          hit_c  = 1'b1;
          data_c = stage_data[k*XLEN +: XLEN];
        end else begin
          stall_c = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dlx_fwd_scoreboard.sv
// Hazard/forwarding scoreboard beside ID: slot shift register, per-source matchers,
// stall reduction and a saturating stall counter.
module dlx_fwd_scoreboard
  import dlx_pipe_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_W      = DEF_REG_W,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 1,
  parameter int unsigned NSRC       = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic                   issue_we,
  input  logic [REG_W-1:0]       issue_rd,
  input  logic                   issue_is_load,
  input  logic                   flush,
  input  logic [NSRC*REG_W-1:0]  src_sel,
  input  logic [DEPTH*XLEN-1:0]  stage_data,
  output logic                   stall,
  output logic [NSRC-1:0]        fwd_hit,
  output logic [NSRC*XLEN-1:0]   fwd_data,
  output logic [CNT_W-1:0]       stall_cnt
);

  slot_t [DEPTH-1:0] slots;
  slot_t             new_slot;
  logic  [NSRC-1:0]  src_stall;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    dlx_fwd_match #(
      .XLEN       (XLEN),
      .REG_W      (REG_W),
      .DEPTH      (DEPTH),
      .LOAD_STAGE (LOAD_STAGE)
    ) u_match (
      .slots      (slots),
      .src        (src_sel[g*REG_W +: REG_W]),
      .stage_data (stage_data),
      .hit_c      (fwd_hit[g]),
      .stall_c    (src_stall[g]),
      .data_c     (fwd_data[g*XLEN +: XLEN])
    );
  end

  assign stall = |src_stall;

  // A killed, stalled or empty ID slot enters EX as a bubble.
  always_comb begin
    new_slot = '0;
    if (issue_valid && !flush && !stall) begin
      new_slot.valid   = 1'b1;
      new_slot.we      = issue_we;
      new_slot.rd      = DEF_REG_W'(issue_rd);
      new_slot.is_load = issue_is_load;
    end
  end

  // Slots drain every cycle, even while stalled, so load-use stalls always resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      slots     <= '0;
      stall_cnt <= '0;
    end else begin
      slots[0] <= new_slot;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        slots[k] <= slots[k-1];
      end
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dlx_fwd_scoreboard.sv
// Directed vector bench: default-parameter instance driven from a cycle table,
// plus a deep-pipeline instance (DEPTH=5, LOAD_STAGE=3, NSRC=3, CNT_W=2).
module tb_dlx_fwd_scoreboard;

  logic clk;

  // Instance A: default parameters
  logic        rst_a, iv_a, we_a, ld_a, fl_a;
  logic [4:0]  rd_a;
  logic [9:0]  src_a;
  logic [95:0] sd_a;
  logic        stall_a;
  logic [1:0]  hit_a;
  logic [63:0] fd_a;
  logic [31:0] cnt_a;

  // Instance B: deep pipeline, narrow counter
  logic         rst_b, iv_b, we_b, ld_b, fl_b;
  logic [4:0]   rd_b;
  logic [14:0]  src_b;
  logic [159:0] sd_b;
  logic         stall_b;
  logic [2:0]   hit_b;
  logic [95:0]  fd_b;
  logic [1:0]   cnt_b;

  int nvec;
  int nmis;

  dlx_fwd_scoreboard u_dut_a (
    .clk (clk), .rst (rst_a), .issue_valid (iv_a), .issue_we (we_a),
    .issue_rd (rd_a), .issue_is_load (ld_a), .flush (fl_a), .src_sel (src_a),
    .stage_data (sd_a), .stall (stall_a), .fwd_hit (hit_a), .fwd_data (fd_a),
    .stall_cnt (cnt_a)
  );

  dlx_fwd_scoreboard #(
    .XLEN (32), .REG_W (5), .DEPTH (5), .LOAD_STAGE (3), .NSRC (3), .CNT_W (2)
  ) u_dut_b (
    .clk (clk), .rst (rst_b), .issue_valid (iv_b), .issue_we (we_b),
    .issue_rd (rd_b), .issue_is_load (ld_b), .flush (fl_b), .src_sel (src_b),
    .stage_data (sd_b), .stall (stall_b), .fwd_hit (hit_b), .fwd_data (fd_b),
    .stall_cnt (cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        iv, we;
    logic [4:0]  rd;
    logic        ld, fl;
    logic [4:0]  s0, s1;
    logic [31:0] d0, d1, d2;
    logic        e_stall;
    logic [1:0]  e_hit;
    logic [31:0] e_fd0, e_fd1, e_cnt;
    logic [1:0]  dc;
  } vec_t;

  localparam int NV = 18;
  localparam logic [31:0] JA = 32'hA0A0_0A0A;
  localparam logic [31:0] JB = 32'hB1B1_1B1B;
  localparam logic [31:0] JC = 32'hC2C2_2C2C;

  vec_t tv [NV];

  function automatic vec_t mk(logic iv, logic we, logic [4:0] rd, logic ld, logic fl,
                              logic [4:0] s0, logic [4:0] s1,
                              logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                              logic e_stall, logic [1:0] e_hit,
                              logic [31:0] e_fd0, logic [31:0] e_fd1,
                              logic [31:0] e_cnt, logic [1:0] dc);
    vec_t v;
    v.iv = iv; v.we = we; v.rd = rd; v.ld = ld; v.fl = fl;
    v.s0 = s0; v.s1 = s1; v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.e_stall = e_stall; v.e_hit = e_hit; v.e_fd0 = e_fd0; v.e_fd1 = e_fd1;
    v.e_cnt = e_cnt; v.dc = dc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step_b(input logic iv, input logic [4:0] rd, input logic ld,
                        input logic [4:0] s0, input logic [4:0] s2,
                        input logic e_stall, input logic [2:0] e_hit,
                        input logic [31:0] e_fd0, input logic [31:0] e_fd2,
                        input logic [1:0] e_cnt, input string tag);
    @(negedge clk);
    rst_b = 1'b0; iv_b = iv; we_b = iv; rd_b = rd; ld_b = ld; fl_b = 1'b0;
    src_b = {s2, 5'd0, s0};
    #1;
    chk({tag, ".stall"}, 32'(stall_b), 32'(e_stall));
    chk({tag, ".hit"}, 32'(hit_b), 32'(e_hit));
    chk({tag, ".cnt"}, 32'(cnt_b), 32'(e_cnt));
    if (!e_stall) begin
      chk({tag, ".fd0"}, fd_b[31:0], e_fd0);
      chk({tag, ".fd2"}, fd_b[95:64], e_fd2);
    end
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    rst_a = 1'b1; iv_a = 1'b0; we_a = 1'b0; rd_a = '0; ld_a = 1'b0; fl_a = 1'b0;
    src_a = '0; sd_a = '0;
    rst_b = 1'b1; iv_b = 1'b0; we_b = 1'b0; rd_b = '0; ld_b = 1'b0; fl_b = 1'b0;
    src_b = '0;
    sd_b = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0F0F_0000};

    //         iv we rd   ld fl s0    s1     d0          d1            d2  stl hit  fd0           fd1       cnt  dc
    tv[0]  = mk(0, 0, 5'd0, 0, 0, 5'd0, 5'd0,  JA,         JB,           JC, 0, 2'b00, 0,            0,        0, 2'b00);
    tv[1]  = mk(1, 1, 5'd3, 0, 0, 5'd0, 5'd0,  JA,         JB,           JC, 0, 2'b00, 0,            0,        0, 2'b00);
    tv[2]  = mk(0, 0, 5'd0, 0, 0, 5'd3, 5'd0,  32'h11,     JB,           JC, 0, 2'b01, 32'h11,       0,        0, 2'b00);
    tv[3]  = mk(1, 1, 5'd5, 0, 0, 5'd0, 5'd0,  JA,         JB,           JC, 0, 2'b00, 0,            0,        0, 2'b00);
    tv[4]  = mk(1, 1, 5'd5, 0, 0, 5'd0, 5'd5,  32'hBB,     JB,           JC, 0, 2'b10, 0,            32'hBB,   0, 2'b00);
    tv[5]  = mk(0, 0, 5'd0, 0, 0, 5'd3, 5'd5,  32'hAA,     32'hBB,       JC, 0, 2'b10, 0,            32'hAA,   0, 2'b00);
    tv[6]  = mk(1, 1, 5'd7, 1, 0, 5'd0, 5'd0,  JA,         JB,           JC, 0, 2'b00, 0,            0,        0, 2'b00);
    tv[7]  = mk(1, 1, 5'd8, 0, 0, 5'd7, 5'd0,  JA,         JB,           JC, 1, 2'b00, 0,            0,        0, 2'b01);
    tv[8]  = mk(1, 1, 5'd8, 0, 0, 5'd7, 5'd0,  JA,         32'hDEAD,     JC, 0, 2'b01, 32'hDEAD,     0,        1, 2'b00);
    tv[9]  = mk(1, 1, 5'd0, 0, 0, 5'd0, 5'd0,  JA,         JB,           JC, 0, 2'b00, 0,            0,        1, 2'b00);
    tv[10] = mk(1, 1, 5'd9, 0, 1, 5'd0, 5'd8,  JA,         32'h88,       JC, 0, 2'b10, 0,            32'h88,   1, 2'b00);
    tv[11] = mk(1, 1, 5'd4, 1, 0, 5'd9, 5'd0,  JA,         JB,           JC, 0, 2'b00, 0,            0,        1, 2'b00);
    tv[12] = mk(1, 1, 5'd10,0, 1, 5'd4, 5'd10, JA,         JB,           JC, 1, 2'b00, 0,            0,        1, 2'b01);
    tv[13] = mk(0, 0, 5'd0, 0, 0, 5'd4, 5'd10, JA,         32'h44,       JC, 0, 2'b01, 32'h44,       0,        2, 2'b00);
    tv[14] = mk(1, 1, 5'd6, 1, 0, 5'd0, 5'd0,  JA,         JB,           JC, 0, 2'b00, 0,            0,        2, 2'b00);
    tv[15] = mk(1, 1, 5'd12,0, 0, 5'd6, 5'd6,  JA,         JB,           JC, 1, 2'b00, 0,            0,        2, 2'b11);
    tv[16] = mk(1, 1, 5'd12,0, 0, 5'd6, 5'd6,  JA,         32'h66,       JC, 0, 2'b11, 32'h66,       32'h66,   3, 2'b00);
    tv[17] = mk(1, 1, 5'd7, 1, 0, 5'd0, 5'd12, 32'h12,     JB,           JC, 0, 2'b10, 0,            32'h12,   3, 2'b00);

    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst_a = 1'b0;
      iv_a = tv[i].iv; we_a = tv[i].we; rd_a = tv[i].rd; ld_a = tv[i].ld; fl_a = tv[i].fl;
      src_a = {tv[i].s1, tv[i].s0};
      sd_a = {tv[i].d2, tv[i].d1, tv[i].d0};
      #1;
      chk($sformatf("v%0d.stall", i), 32'(stall_a), 32'(tv[i].e_stall));
      chk($sformatf("v%0d.hit", i), 32'(hit_a), 32'(tv[i].e_hit));
      chk($sformatf("v%0d.cnt", i), cnt_a, tv[i].e_cnt);
      if (!tv[i].dc[0]) chk($sformatf("v%0d.fd0", i), fd_a[31:0], tv[i].e_fd0);
      if (!tv[i].dc[1]) chk($sformatf("v%0d.fd1", i), fd_a[63:32], tv[i].e_fd1);
    end

    // Reset asserted during a load-use stall on r7
    @(negedge clk);
    iv_a = 1'b1; we_a = 1'b1; rd_a = 5'd13; ld_a = 1'b0; src_a = {5'd0, 5'd7};
    rst_a = 1'b1;
    #1;
    chk("rst.pre_stall", 32'(stall_a), 32'd1);
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    chk("rst.stall", 32'(stall_a), 32'd0);
    chk("rst.hit", 32'(hit_a), 32'd0);
    chk("rst.fd0", fd_a[31:0], 32'd0);
    chk("rst.cnt", cnt_a, 32'd0);

    // Deep pipeline: three-cycle load-use, forward from slot 3, counter saturation
    step_b(1'b0, 5'd0,  1'b0, 5'd0,  5'd0, 1'b0, 3'b000, 0, 0, 2'd0, "b.reset");
    step_b(1'b1, 5'd2,  1'b1, 5'd0,  5'd0, 1'b0, 3'b000, 0, 0, 2'd0, "b.lw");
    step_b(1'b1, 5'd11, 1'b0, 5'd0,  5'd2, 1'b1, 3'b000, 0, 0, 2'd0, "b.st1");
    step_b(1'b1, 5'd11, 1'b0, 5'd0,  5'd2, 1'b1, 3'b000, 0, 0, 2'd1, "b.st2");
    step_b(1'b1, 5'd11, 1'b0, 5'd0,  5'd2, 1'b1, 3'b000, 0, 0, 2'd2, "b.st3");
    step_b(1'b1, 5'd11, 1'b0, 5'd0,  5'd2, 1'b0, 3'b100, 0, 32'h3333_0003, 2'd3, "b.fwd3");
    step_b(1'b1, 5'd12, 1'b1, 5'd11, 5'd2, 1'b0, 3'b101, 32'h0F0F_0000, 32'h4444_0004,
           2'd3, "b.fwd04");
    step_b(1'b0, 5'd0,  1'b0, 5'd12, 5'd0, 1'b1, 3'b000, 0, 0, 2'd3, "b.st_sat");
    step_b(1'b0, 5'd0,  1'b0, 5'd0,  5'd0, 1'b0, 3'b000, 0, 0, 2'd3, "b.sat");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
